mii_tx_framer: RTL and testbench



---
 rtl/mii_tx_pkg.sv | 12 +
 rtl/crc32_d4.sv | 16 +
 rtl/mii_tx_framer.sv | 140 ++++++++++++++
 tb/tb_mii_tx_framer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mii_tx_pkg.sv
// mii_tx_pkg: shared states and constants for the MII transmit framer and CRC step
package mii_tx_pkg;
  typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG} state_t;
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [3:0] NIB_PREAMBLE = 4'h5;
  localparam logic [3:0] NIB_SFD = 4'hD;
  localparam int STAT_UNDERRUN = 17;
  localparam int STAT_ERR = 16;
  localparam int STAT_LEN_MSB = 15;
endpackage

// File: rtl/crc32_d4.sv
// crc32_d4: one reflected CRC-32 step over a nibble, LSB first
module crc32_d4
  import mii_tx_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [3:0]  i_nib,
  output logic [31:0] o_crc
);
  logic [31:0] w_c;
  always_comb begin
    w_c = i_crc;
    for (int i = 0; i < 4; i++)
      w_c = (w_c >> 1) ^ ((w_c[0] ^ i_nib[i]) ? CRC_POLY : 32'h0);
  end
  assign o_crc = w_c;
endmodule

// File: rtl/mii_tx_framer.sv
// mii_tx_framer: byte stream to MII nibbles with preamble/SFD, padding, FCS and IFG
module mii_tx_framer
  import mii_tx_pkg::*;
#(
  parameter int MIN_FRAME_BYTES = 60,
  parameter int PREAMBLE_NIBBLES = 15,
  parameter int IFG_NIBBLES = 24
) (
  input  logic        phy_tx_clk,
  input  logic        reset,
  input  logic [7:0]  tx_mac_data,
  input  logic        tx_mac_valid,
  input  logic        tx_mac_last,
  input  logic        tx_mac_err,
  output logic        tx_mac_ready,
  output logic        phy_tx_en,
  output logic [3:0]  phy_txd,
  output logic        phy_tx_err,
  output logic        tx_stat_valid,
  output logic [17:0] tx_stat_vector
);
  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_NIBBLES - 1);
  localparam logic [7:0] IFG_LAST = 8'(IFG_NIBBLES - 1);
  localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_BYTES);
  state_t r_state, w_state;
  logic [7:0] r_cnt, w_cnt, r_hold, w_hold;
  logic r_phase, w_phase, r_last, w_last, r_err, w_err, r_ur, w_ur, r_eflag, w_eflag;
  logic [15:0] r_bytes, w_bytes, w_bytes_inc;
  logic [16:0] w_len4;
  logic [31:0] r_crc, w_crc, w_crc_step;
  logic [3:0] w_nib, w_txd;
  logic w_accept, w_tx_en, w_tx_er, w_stat;
  assign tx_mac_ready = !reset && (r_state == S_IDLE || (r_state == S_DATA && r_phase && !r_last));
  assign w_accept = tx_mac_valid && tx_mac_ready;
  assign w_nib = r_state == S_PAD ? 4'h0 : (r_phase ? r_hold[7:4] : r_hold[3:0]);
  assign w_bytes_inc = r_bytes == 16'hFFFF ? r_bytes : r_bytes + 16'd1;
  assign w_len4 = {1'b0, r_bytes} + 17'd4;
  assign w_stat = w_state == S_IFG && r_state != S_IFG;
  crc32_d4 u_crc (.i_crc(r_crc), .i_nib(w_nib), .o_crc(w_crc_step));
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt + 8'd1;
    w_phase = r_phase;
    w_hold = r_hold;
    w_last = r_last;
    w_err = r_err;
    w_ur = r_ur;
    w_eflag = r_eflag;
    w_bytes = r_bytes;
    w_crc = r_crc;
    if (w_accept) begin
      w_hold = tx_mac_data;
      w_last = tx_mac_last;
      w_err = tx_mac_err;
      w_bytes = r_state == S_IDLE ? 16'd1 : w_bytes_inc;
      w_eflag = (r_state != S_IDLE && r_eflag) || tx_mac_err;
    end
    case (r_state)
      S_IDLE: if (w_accept) begin
        w_state = S_PREAMBLE;
        w_ur = 1'b0;
      end
      S_PREAMBLE: if (r_cnt == PRE_LAST) w_state = S_SFD;
      S_SFD: begin
        w_state = S_DATA;
        w_phase = 1'b0;
        w_crc = CRC_INIT;
      end
      S_DATA: begin
        w_phase = !r_phase;
        w_crc = w_crc_step;
        if (r_ur) w_state = S_IFG;
        else if (r_phase && r_last) w_state = r_bytes < MIN_LEN ? S_PAD : S_FCS;
        else if (r_phase && !tx_mac_valid) w_ur = 1'b1;
      end
      S_PAD: begin
        w_phase = !r_phase;
        w_crc = w_crc_step;
        if (r_phase) begin
          w_bytes = w_bytes_inc;
          if (w_bytes_inc >= MIN_LEN) w_state = S_FCS;
        end
      end
      // FCS streams out of the register low nibble first
      S_FCS: begin
        w_crc = r_crc >> 4;
        if (r_cnt == 8'd7) w_state = S_IFG;
      end
      S_IFG: if (r_cnt == IFG_LAST) w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
    if (w_state != r_state) w_cnt = 8'd0;
    w_tx_en = w_state inside {S_PREAMBLE, S_SFD, S_DATA, S_PAD, S_FCS};
    w_txd = w_state == S_PREAMBLE ? NIB_PREAMBLE :
            w_state == S_SFD ? NIB_SFD :
            w_state == S_FCS ? ~w_crc[3:0] :
            (w_state == S_DATA && !w_ur) ? (w_phase ? w_hold[7:4] : w_hold[3:0]) : 4'h0;
    w_tx_er = w_state == S_DATA && (w_ur || w_err);
  end
  // outputs register the decode of the next state so pins line up with r_state
  always_ff @(posedge phy_tx_clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_hold <= '0;
      r_phase <= 1'b0;
      r_last <= 1'b0;
      r_err <= 1'b0;
      r_ur <= 1'b0;
      r_eflag <= 1'b0;
      r_bytes <= '0;
      r_crc <= CRC_INIT;
      phy_tx_en <= 1'b0;
      phy_txd <= '0;
      phy_tx_err <= 1'b0;
      tx_stat_valid <= 1'b0;
      tx_stat_vector <= '0;
    end else begin
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_hold <= w_hold;
      r_phase <= w_phase;
      r_last <= w_last;
      r_err <= w_err;
      r_ur <= w_ur;
      r_eflag <= w_eflag;
      r_bytes <= w_bytes;
      r_crc <= w_crc;
      phy_tx_en <= w_tx_en;
      phy_txd <= w_txd;
      phy_tx_err <= w_tx_er;
      tx_stat_valid <= w_stat;
      if (w_stat) begin
        tx_stat_vector[STAT_UNDERRUN] <= r_ur;
        tx_stat_vector[STAT_ERR] <= r_eflag;
        tx_stat_vector[STAT_LEN_MSB:0] <= r_ur ? r_bytes : (w_len4[16] ? 16'hFFFF : w_len4[15:0]);
      end
    end
  end
endmodule

// File: tb/tb_mii_tx_framer.sv
// tb_mii_tx_framer: directed and random frames checked against a byte-level frame model
module tb_mii_tx_framer;
  import mii_tx_pkg::*;
  localparam int PRE = 15;
  localparam int MINB = 60;
  logic clk = 0, rst = 1;
  logic [7:0] data = 0;
  logic valid = 0, last = 0, err = 0;
  logic ready, tx_en, tx_er, stat_v;
  logic [3:0] txd;
  logic [17:0] stat;
  int checks = 0, errors = 0;
  logic [7:0] fb[$];
  logic [4:0] cap_q[$];
  logic [17:0] stat_q[$];
  int run_q[$], gap_q[$], rgap_q[$], sgap_q[$];

  always #5 clk = ~clk;

  mii_tx_framer dut (
    .phy_tx_clk(clk), .reset(rst), .tx_mac_data(data), .tx_mac_valid(valid),
    .tx_mac_last(last), .tx_mac_err(err), .tx_mac_ready(ready), .phy_tx_en(tx_en),
    .phy_txd(txd), .phy_tx_err(tx_er), .tx_stat_valid(stat_v), .tx_stat_vector(stat)
  );

  initial begin
    int run = 0, gap = 0, rgap = 0;
    logic prev = 0;
    forever begin
      @(negedge clk);
      if (tx_en) begin
        if (!prev) begin gap_q.push_back(gap); rgap_q.push_back(rgap); end
        cap_q.push_back({tx_er, txd});
        run++;
      end else begin
        if (prev) begin run_q.push_back(run); run = 0; gap = 0; rgap = 0; end
        gap++;
        if (ready) rgap++;
      end
      if (stat_v) begin stat_q.push_back(stat); sgap_q.push_back(gap); end
      prev = tx_en;
    end
  end

  initial begin
    #600000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] crc_bytes(input logic [7:0] b[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    end
    return c;
  endfunction

  task automatic clear();
    cap_q.delete(); stat_q.delete(); run_q.delete();
    gap_q.delete(); rgap_q.delete(); sgap_q.delete();
  endtask

  task automatic rand_fb(input int n);
    fb.delete();
    for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
  endtask

  task automatic send(input int n, input int err_idx, input int ur_after, input bit keep);
    int i = 0, lim = 0;
    int cnt = ur_after > 0 ? ur_after : n;
    logic r;
    while (i < cnt && lim < 4000) begin
      @(negedge clk);
      valid = 1; data = fb[i]; last = ur_after == 0 && i == n - 1; err = i == err_idx;
      r = ready;
      @(posedge clk);
      if (r) i++;
      lim++;
    end
    checks++;
    assert (i == cnt) else begin errors++; $error("FAIL send_accept got %0d need %0d", i, cnt); end
    if (!keep) begin @(negedge clk); valid = 0; last = 0; err = 0; end
  endtask

  task automatic wait_stat(input int k);
    int lim = 0;
    while (stat_q.size() < k && lim < 3000) begin @(posedge clk); lim++; end
    checks++;
    assert (stat_q.size() >= k) else begin errors++; $error("FAIL stat_wait got %0d need %0d", stat_q.size(), k); end
    @(posedge clk); #1;
  endtask

  task automatic check_frame(input int n, input int err_idx, input int ur_after, input int exp_gap);
    logic [4:0] exp[$], got[$];
    logic [7:0] body[$], rx[$];
    logic [31:0] fcs;
    logic [17:0] exp_stat, got_stat;
    int sent = ur_after > 0 ? ur_after : n;
    int got_len, bad, sg, g, rg;
    bit anyerr = 0;
    for (int i = 0; i < PRE; i++) exp.push_back({1'b0, NIB_PREAMBLE});
    exp.push_back({1'b0, NIB_SFD});
    for (int i = 0; i < sent; i++) begin
      exp.push_back({i == err_idx, fb[i][3:0]});
      exp.push_back({i == err_idx, fb[i][7:4]});
      body.push_back(fb[i]);
      if (i == err_idx) anyerr = 1;
    end
    if (ur_after > 0) begin
      exp.push_back(5'h10);
      exp_stat = {1'b1, anyerr, 16'(sent)};
    end else begin
      while (body.size() < MINB) begin
        body.push_back(8'h00);
        exp.push_back(5'h00);
        exp.push_back(5'h00);
      end
      fcs = ~crc_bytes(body);
      for (int k = 0; k < 8; k++) exp.push_back({1'b0, fcs[4*k +: 4]});
      exp_stat = {1'b0, anyerr, 16'(body.size() + 4)};
    end
    got_len = run_q.size() > 0 ? run_q.pop_front() : -1;
    checks++;
    assert (got_len == exp.size()) else begin errors++; $error("FAIL tx_en_len got %0d exp %0d", got_len, exp.size()); end
    for (int i = 0; i < got_len && cap_q.size() > 0; i++) got.push_back(cap_q.pop_front());
    bad = -1;
    for (int i = 0; i < exp.size(); i++)
      if (bad < 0 && (i >= got.size() || got[i] !== exp[i])) bad = i;
    checks++;
    assert (bad < 0) else begin
      errors++;
      $error("FAIL stream nibble %0d got {er,txd}=%h exp %h", bad, bad < got.size() ? got[bad] : 5'h1f, exp[bad]);
    end
    got_stat = stat_q.size() > 0 ? stat_q.pop_front() : 18'h3FFFF;
    sg = sgap_q.size() > 0 ? sgap_q.pop_front() : -1;
    checks++;
    assert (got_stat === exp_stat) else begin errors++; $error("FAIL stat_vector got %h exp %h", got_stat, exp_stat); end
    checks++;
    assert (sg == 1) else begin errors++; $error("FAIL stat_timing idle_cycle %0d exp 1", sg); end
    g = gap_q.size() > 0 ? gap_q.pop_front() : -1;
    rg = rgap_q.size() > 0 ? rgap_q.pop_front() : -1;
    if (exp_gap >= 0) begin
      checks++;
      assert (g == exp_gap && rg == 1) else begin
        errors++; $error("FAIL ifg_gap got %0d ready_cycles %0d exp %0d ready_cycles 1", g, rg, exp_gap);
      end
    end
    if (ur_after == 0 && got.size() == exp.size()) begin
      for (int i = PRE + 1; i + 1 < got.size(); i += 2) rx.push_back({got[i+1][3:0], got[i][3:0]});
      checks++;
      assert (crc_bytes(rx) == CRC_RESIDUE) else begin
        errors++; $error("FAIL rx_residue got %h exp %h", crc_bytes(rx), CRC_RESIDUE);
      end
    end
  endtask

  initial begin
    int lim;
    int n, e, u;
    valid = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    assert ({tx_en, txd, tx_er, stat_v, stat} === 25'h0) else begin
      errors++; $error("FAIL reset_outputs got %h exp 0", {tx_en, txd, tx_er, stat_v, stat});
    end
    checks++;
    assert (ready === 1'b0) else begin errors++; $error("FAIL reset_ready got %b exp 0", ready); end
    @(negedge clk); rst = 0; valid = 0;
    @(negedge clk);
    checks++;
    assert (ready === 1'b1) else begin errors++; $error("FAIL idle_ready got %b exp 1", ready); end

    clear(); fb.delete();
    for (int i = 0; i < 60; i++) fb.push_back(8'(i));
    send(60, -1, 0, 0); wait_stat(1); check_frame(60, -1, 0, -1);

    clear(); fb.delete(); fb.push_back(8'hAB);
    send(1, -1, 0, 0); wait_stat(1); check_frame(1, -1, 0, -1);

    clear(); rand_fb(64);
    send(64, -1, 20, 0); wait_stat(1); check_frame(64, -1, 20, -1);

    clear(); rand_fb(64);
    send(64, 5, 0, 0); wait_stat(1); check_frame(64, 5, 0, -1);

    clear(); fb.delete();
    for (int i = 0; i < 60; i++) fb.push_back(8'(i));
    send(60, -1, 0, 1); send(60, -1, 0, 0); wait_stat(2);
    check_frame(60, -1, 0, -1); check_frame(60, -1, 0, PRE + 10);

    repeat (30) @(posedge clk);
    clear();
    @(negedge clk); valid = 1; data = 8'h11; last = 0; err = 0;
    lim = 0;
    while (!(tx_en && txd == NIB_SFD) && lim < 100) begin @(negedge clk); lim++; end
    checks++;
    assert (tx_en && txd == NIB_SFD) else begin errors++; $error("FAIL sfd_reach got en=%b txd=%h exp en=1 txd=d", tx_en, txd); end
    rst = 1; valid = 0;
    @(posedge clk); #1;
    checks++;
    assert ({tx_en, txd, tx_er, stat_v, stat} === 25'h0) else begin
      errors++; $error("FAIL sfd_reset_outputs got %h exp 0", {tx_en, txd, tx_er, stat_v, stat});
    end
    checks++;
    assert (ready === 1'b0) else begin errors++; $error("FAIL sfd_reset_ready got %b exp 0", ready); end
    @(negedge clk); rst = 0;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    assert (stat_q.size() == 0) else begin errors++; $error("FAIL abort_stat got %0d pulses exp 0", stat_q.size()); end
    clear(); rand_fb(70);
    send(70, -1, 0, 0); wait_stat(1); check_frame(70, -1, 0, -1);

    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 90);
      e = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
      u = ($urandom_range(0, 3) == 0 && n > 2) ? $urandom_range(1, n - 1) : 0;
      clear(); rand_fb(n);
      send(n, e, u, 0); wait_stat(1); check_frame(n, e, u, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
